// File: rtl/jump_resolve.sv
// rtl/jump_resolve.sv - EX-stage control-flow resolution: redirect cause/target, wrong-path flush, branch counters.
// Exceptions beat a pending interrupt, which beats jump/mispredict redirects.
module jump_resolve #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [ADDR_W-1:0] ex_pc_i,
  input  logic              ex_is_branch_i,
  input  logic              ex_is_jump_i,
  input  logic              ex_taken_i,
  input  logic [ADDR_W-1:0] ex_target_i,
  input  logic              ex_predicted_i,
  input  logic              ex_except_i,
  input  logic              irq_i,
  input  logic [ADDR_W-1:0] trap_vec_i,
  input  logic              hold_i,
  output logic [2:0]        jump_cause_o,
  output logic [ADDR_W-1:0] jump_from_addr_o,
  output logic [ADDR_W-1:0] jump_to_addr_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  branch_cnt_o,
  output logic [CNT_W-1:0]  mispredict_cnt_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_PNY  = 3'b001;
  localparam logic [2:0] C_PYN  = 3'b010;
  localparam logic [2:0] C_NOC  = 3'b011;
  localparam logic [2:0] C_IRQ  = 3'b100;
  localparam logic [2:0] C_EXC  = 3'b101;

  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  logic [0:0]        state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              irq_pend_q, irq_pend_d;
  logic [2:0]        cause_q, cause_d;
  logic [ADDR_W-1:0] from_q, from_d;
  logic [ADDR_W-1:0] to_q, to_d;
  logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0]  mp_cnt_q, mp_cnt_d;

  logic              accept;
  logic              is_jump;
  logic              is_branch;
  logic [ADDR_W-1:0] pc_plus4;

  assign accept    = ex_valid_i & ~hold_i & (state_q == ST_IDLE);
  // A jal/jalr that also flags as branch is still unconditional.
  assign is_jump   = ex_is_jump_i;
  assign is_branch = ex_is_branch_i & ~ex_is_jump_i;
  assign pc_plus4  = ex_pc_i + ADDR_W'(4);

  always_comb begin
    cause_d    = C_NONE;
    from_d     = from_q;
    to_d       = to_q;
    br_cnt_d   = br_cnt_q;
    mp_cnt_d   = mp_cnt_q;
    irq_pend_d = irq_pend_q | irq_i;

    if (accept) begin
      if (ex_except_i) begin
        cause_d = C_EXC;
        to_d    = trap_vec_i;
      end else if (irq_pend_q) begin
        cause_d    = C_IRQ;
        to_d       = trap_vec_i;
        irq_pend_d = irq_i;
      end else if (is_jump) begin
        cause_d = C_NOC;
        to_d    = ex_target_i;
      end else if (is_branch) begin
        br_cnt_d = br_cnt_q + 1'b1;
        if (ex_taken_i && !ex_predicted_i) begin
          cause_d  = C_PNY;
          to_d     = ex_target_i;
          mp_cnt_d = mp_cnt_q + 1'b1;
        end else if (!ex_taken_i && ex_predicted_i) begin
          cause_d  = C_PYN;
          to_d     = pc_plus4;
          mp_cnt_d = mp_cnt_q + 1'b1;
        end
      end
    end

    if (cause_d != C_NONE) begin
      from_d = ex_pc_i;
    end
  end

  // The cause cycle itself is the first squash cycle.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (state_q == ST_IDLE) begin
      if (cause_d != C_NONE) begin
        state_d = ST_FLUSH;
        fcnt_d  = FLUSH_LAST;
      end
    end else begin
      if (fcnt_q == 3'd0) begin
        state_d = ST_IDLE;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fcnt_q     <= 3'd0;
      irq_pend_q <= 1'b0;
      cause_q    <= C_NONE;
      from_q     <= '0;
      to_q       <= '0;
      br_cnt_q   <= '0;
      mp_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      irq_pend_q <= irq_pend_d;
      cause_q    <= cause_d;
      from_q     <= from_d;
      to_q       <= to_d;
      br_cnt_q   <= br_cnt_d;
      mp_cnt_q   <= mp_cnt_d;
    end
  end

  assign jump_cause_o     = cause_q;
  assign jump_from_addr_o = from_q;
  assign jump_to_addr_o   = to_q;
  assign flush_o          = (state_q == ST_FLUSH);
  assign branch_cnt_o     = br_cnt_q;
  assign mispredict_cnt_o = mp_cnt_q;

endmodule

// File: tb/tb_jump_resolve.sv
// tb/tb_jump_resolve.sv - scoreboard bench for jump_resolve.
module tb_jump_resolve;

  localparam logic [31:0] TRAP = 32'hBEEF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, ex_is_branch_i, ex_is_jump_i, ex_taken_i;
  logic        ex_predicted_i, ex_except_i, irq_i, hold_i;
  logic [31:0] ex_pc_i, ex_target_i, trap_vec_i;
  logic [2:0]  jump_cause_o;
  logic [31:0] jump_from_addr_o, jump_to_addr_o;
  logic        flush_o;
  logic [31:0] branch_cnt_o, mispredict_cnt_o;

  always #5 clk = ~clk;

  jump_resolve #(.ADDR_W(32), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .ex_valid_i       (ex_valid_i),
    .ex_pc_i          (ex_pc_i),
    .ex_is_branch_i   (ex_is_branch_i),
    .ex_is_jump_i     (ex_is_jump_i),
    .ex_taken_i       (ex_taken_i),
    .ex_target_i      (ex_target_i),
    .ex_predicted_i   (ex_predicted_i),
    .ex_except_i      (ex_except_i),
    .irq_i            (irq_i),
    .trap_vec_i       (trap_vec_i),
    .hold_i           (hold_i),
    .jump_cause_o     (jump_cause_o),
    .jump_from_addr_o (jump_from_addr_o),
    .jump_to_addr_o   (jump_to_addr_o),
    .flush_o          (flush_o),
    .branch_cnt_o     (branch_cnt_o),
    .mispredict_cnt_o (mispredict_cnt_o)
  );

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] f;
    logic [31:0] t;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_br = 0;
  logic [31:0] exp_mp = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    ex_valid_i = 0; ex_is_branch_i = 0; ex_is_jump_i = 0; ex_taken_i = 0;
    ex_predicted_i = 0; ex_except_i = 0; irq_i = 0; hold_i = 0;
    ex_pc_i = 0; ex_target_i = 0;
  endtask

  // Drive one instruction for one edge; expected result queued now, popped once the DUT registers it.
  task automatic issue(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                       input logic [31:0] tgt, input logic pr, input logic exc,
                       input logic [2:0] ec, input logic [31:0] ef, input logic [31:0] et);
    ex_valid_i = 1; ex_pc_i = pc; ex_is_branch_i = br; ex_is_jump_i = jmp; ex_taken_i = tk;
    ex_target_i = tgt; ex_predicted_i = pr; ex_except_i = exc; hold_i = 0;
    sbq.push_back({ec, ef, et});
    step();
    quiet();
    e = sbq.pop_front();
  endtask

  task automatic test_reset();
    rst = 1; quiet(); trap_vec_i = TRAP;
    step(); step();
    n_cmp++; if (jump_cause_o !== 3'd0) begin n_err++; $display("FAIL reset_cause: got %0h want 0", jump_cause_o); end
    n_cmp++; if (jump_from_addr_o !== 32'd0) begin n_err++; $display("FAIL reset_from: got %0h want 0", jump_from_addr_o); end
    n_cmp++; if (jump_to_addr_o !== 32'd0) begin n_err++; $display("FAIL reset_to: got %0h want 0", jump_to_addr_o); end
    n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL reset_flush: got %0b want 0", flush_o); end
    n_cmp++; if (branch_cnt_o !== 32'd0 || mispredict_cnt_o !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", branch_cnt_o, mispredict_cnt_o); end
    rst = 0;
    step();
  endtask

  task automatic test_correct_predict();
    issue(32'h40, 1, 0, 1, 32'h80, 1, 0, 3'd0, 32'h0, 32'h0);
    exp_br++;
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL cp_cause: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL cp_flush: got %0b want 0", flush_o); end
    n_cmp++; if (branch_cnt_o !== 32'd1) begin n_err++; $display("FAIL cp_brcnt: got %0d want 1", branch_cnt_o); end
    n_cmp++; if (mispredict_cnt_o !== 32'd0) begin n_err++; $display("FAIL cp_mpcnt: got %0d want 0", mispredict_cnt_o); end
  endtask

  task automatic test_mispredict_taken();
    issue(32'h100, 1, 0, 1, 32'h80, 0, 0, 3'd1, 32'h100, 32'h80);
    exp_br++; exp_mp++;
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL mpt_cause: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (jump_from_addr_o !== e.f) begin n_err++; $display("FAIL mpt_from: got %0h want %0h", jump_from_addr_o, e.f); end
    n_cmp++; if (jump_to_addr_o !== e.t) begin n_err++; $display("FAIL mpt_to: got %0h want %0h", jump_to_addr_o, e.t); end
    n_cmp++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL mpt_flush1: got %0b want 1", flush_o); end
    n_cmp++; if (mispredict_cnt_o !== exp_mp) begin n_err++; $display("FAIL mpt_mpcnt: got %0d want %0d", mispredict_cnt_o, exp_mp); end
    step();
    n_cmp++; if (flush_o !== 1'b1 || jump_cause_o !== 3'd0) begin
      n_err++; $display("FAIL mpt_flush2: got flush %0b cause %0h want 1/0", flush_o, jump_cause_o); end
    step();
    n_cmp++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL mpt_flush_end: got %0b want 0", flush_o); end
  endtask

  task automatic test_wrap_and_wrong_path();
    issue(32'hFFFF_FFFC, 1, 0, 0, 32'h1234, 1, 0, 3'd2, 32'hFFFF_FFFC, 32'h0);
    exp_br++; exp_mp++;
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL wrap_cause: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (jump_from_addr_o !== e.f) begin n_err++; $display("FAIL wrap_from: got %0h want %0h", jump_from_addr_o, e.f); end
    n_cmp++; if (jump_to_addr_o !== e.t) begin n_err++; $display("FAIL wrap_to: got %0h want %0h", jump_to_addr_o, e.t); end
    // Wrong-path branch with an exception presented in both squash cycles.
    ex_valid_i = 1; ex_is_branch_i = 1; ex_taken_i = 1; ex_predicted_i = 0; ex_except_i = 1;
    ex_pc_i = 32'h500; ex_target_i = 32'h600;
    step();
    n_cmp++; if (jump_cause_o !== 3'd0 || flush_o !== 1'b1) begin
      n_err++; $display("FAIL wp_cycle1: got cause %0h flush %0b want 0/1", jump_cause_o, flush_o); end
    n_cmp++; if (jump_to_addr_o !== 32'h0) begin n_err++; $display("FAIL wp_to_hold: got %0h want 0", jump_to_addr_o); end
    step();
    quiet();
    n_cmp++; if (jump_cause_o !== 3'd0 || flush_o !== 1'b0) begin
      n_err++; $display("FAIL wp_cycle2: got cause %0h flush %0b want 0/0", jump_cause_o, flush_o); end
    n_cmp++; if (branch_cnt_o !== exp_br || mispredict_cnt_o !== exp_mp) begin
      n_err++; $display("FAIL wp_cnt: got %0d/%0d want %0d/%0d", branch_cnt_o, mispredict_cnt_o, exp_br, exp_mp); end
  endtask

  task automatic test_jump();
    issue(32'h300, 1, 1, 0, 32'h400, 1, 0, 3'd3, 32'h300, 32'h400);
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL jmp_cause: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (jump_to_addr_o !== e.t) begin n_err++; $display("FAIL jmp_to: got %0h want %0h", jump_to_addr_o, e.t); end
    n_cmp++; if (branch_cnt_o !== exp_br) begin n_err++; $display("FAIL jmp_brcnt: got %0d want %0d", branch_cnt_o, exp_br); end
    step(); step();
  endtask

  task automatic test_irq_exception();
    hold_i = 1; irq_i = 1; ex_valid_i = 1; ex_is_branch_i = 1; ex_taken_i = 1; ex_pc_i = 32'h600; ex_target_i = 32'h700;
    step();
    quiet();
    n_cmp++; if (jump_cause_o !== 3'd0 || flush_o !== 1'b0) begin
      n_err++; $display("FAIL hold_block: got cause %0h flush %0b want 0/0", jump_cause_o, flush_o); end
    issue(32'h200, 0, 1, 1, 32'h900, 0, 1, 3'd5, 32'h200, TRAP);
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL exc_cause: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (jump_from_addr_o !== e.f || jump_to_addr_o !== e.t) begin
      n_err++; $display("FAIL exc_addr: got %0h->%0h want %0h->%0h", jump_from_addr_o, jump_to_addr_o, e.f, e.t); end
    step(); step();
    issue(32'h204, 1, 0, 1, 32'h500, 0, 0, 3'd4, 32'h204, TRAP);
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL irq_cause: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (jump_from_addr_o !== e.f || jump_to_addr_o !== e.t) begin
      n_err++; $display("FAIL irq_addr: got %0h->%0h want %0h->%0h", jump_from_addr_o, jump_to_addr_o, e.f, e.t); end
    n_cmp++; if (branch_cnt_o !== exp_br || mispredict_cnt_o !== exp_mp) begin
      n_err++; $display("FAIL irq_cnt: got %0d/%0d want %0d/%0d", branch_cnt_o, mispredict_cnt_o, exp_br, exp_mp); end
    step(); step();
    issue(32'h208, 1, 0, 1, 32'h700, 0, 0, 3'd1, 32'h208, 32'h700);
    exp_br++; exp_mp++;
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL irq_cleared: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (branch_cnt_o !== exp_br || mispredict_cnt_o !== exp_mp) begin
      n_err++; $display("FAIL post_irq_cnt: got %0d/%0d want %0d/%0d", branch_cnt_o, mispredict_cnt_o, exp_br, exp_mp); end
    step(); step();
  endtask

  task automatic test_reset_mid_flush();
    issue(32'h120, 1, 0, 1, 32'h140, 0, 0, 3'd1, 32'h120, 32'h140);
    irq_i = 1;
    step();
    irq_i = 0;
    n_cmp++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL rmf_flush2: got %0b want 1", flush_o); end
    rst = 1;
    step();
    rst = 0;
    exp_br = 0; exp_mp = 0;
    n_cmp++; if (flush_o !== 1'b0 || jump_cause_o !== 3'd0) begin
      n_err++; $display("FAIL rmf_state: got flush %0b cause %0h want 0/0", flush_o, jump_cause_o); end
    n_cmp++; if (jump_from_addr_o !== 32'd0 || jump_to_addr_o !== 32'd0) begin
      n_err++; $display("FAIL rmf_addr: got %0h/%0h want 0/0", jump_from_addr_o, jump_to_addr_o); end
    n_cmp++; if (branch_cnt_o !== exp_br || mispredict_cnt_o !== exp_mp) begin
      n_err++; $display("FAIL rmf_cnt: got %0d/%0d want 0/0", branch_cnt_o, mispredict_cnt_o); end
    issue(32'h160, 1, 0, 0, 32'h0, 1, 0, 3'd2, 32'h160, 32'h164);
    exp_br++; exp_mp++;
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL rmf_after: got %0h want %0h", jump_cause_o, e.c); end
    n_cmp++; if (jump_to_addr_o !== e.t) begin n_err++; $display("FAIL rmf_after_to: got %0h want %0h", jump_to_addr_o, e.t); end
    step(); step();
  endtask

  task automatic test_back_to_back();
    issue(32'h10, 1, 0, 0, 32'h80, 0, 0, 3'd0, 32'h0, 32'h0);
    exp_br++;
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL b2b_0: got %0h want %0h", jump_cause_o, e.c); end
    issue(32'h14, 1, 0, 1, 32'h20, 1, 0, 3'd0, 32'h0, 32'h0);
    exp_br++;
    n_cmp++; if (jump_cause_o !== e.c) begin n_err++; $display("FAIL b2b_1: got %0h want %0h", jump_cause_o, e.c); end
    issue(32'h18, 0, 0, 0, 32'h0, 0, 0, 3'd0, 32'h0, 32'h0);
    n_cmp++; if (branch_cnt_o !== exp_br) begin n_err++; $display("FAIL b2b_plain_cnt: got %0d want %0d", branch_cnt_o, exp_br); end
    issue(32'h1C, 1, 0, 1, 32'h40, 0, 0, 3'd1, 32'h1C, 32'h40);
    exp_br++; exp_mp++;
    n_cmp++; if (jump_cause_o !== e.c || jump_to_addr_o !== e.t) begin
      n_err++; $display("FAIL b2b_mp: got %0h->%0h want %0h->%0h", jump_cause_o, jump_to_addr_o, e.c, e.t); end
    n_cmp++; if (branch_cnt_o !== exp_br || mispredict_cnt_o !== exp_mp) begin
      n_err++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", branch_cnt_o, mispredict_cnt_o, exp_br, exp_mp); end
    step(); step();
  endtask

  initial begin
    quiet();
    trap_vec_i = TRAP;
    rst = 1;
    test_reset();
    test_correct_predict();
    test_mispredict_taken();
    test_wrap_and_wrong_path();
    test_jump();
    test_irq_exception();
    test_reset_mid_flush();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
